chunked_serial_adder: RTL and testbench

- Multi-cycle, parametrised N-bit adder/subtractor. Processes W bits per clock through one W-bit ripple adder slice and keeps the carry in a register between slices.
- Successor to the combinational n-bit full adder. Adds a start/done handshake, a subtract mode and a configurable trade-off between area and latency.
- Sits between operand registers and the datapath result bus of the course ALU.

---
 rtl/chunked_serial_adder.sv | 194 +++++++++++++++++++
 tb/tb_chunked_serial_adder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle N-bit adder/subtractor. One W-bit ripple slice is evaluated per
// clock, with the inter-slice carry kept in a register, so an operation takes
// K = N/W cycles. A start/busy/done handshake frames each operation.
//
// Parameters:
//   N : operand/sum width (must be a multiple of W, N >= W)
//   W : slice width, bits added per clock
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request a new operation (accepted only when not busy)
//   sub    : 0 -> a + b + ci, 1 -> a - b (ci ignored)
//   a, b   : operands, sampled on the accepting edge only
//   ci     : carry-in for add
//   busy   : high while slices are being computed
//   done   : one-cycle pulse, sum/co (and ovf) valid
//   sum    : result register
//   co     : final carry-out (subtract: 1 = no borrow)
//   ovf    : signed overflow, only when OVF_FLAG_EN is defined
//
// Build option:
//   OVF_FLAG_EN : adds the ovf port and its signed-overflow register.
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co
`ifdef OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;

  logic [W-1:0]  a_slice;
  logic [W-1:0]  b_slice;
  logic [W-1:0]  s_slice;
  logic          c_slice;
  logic [W:0]    slice_res;

  // Select the slice addressed by the counter. A constant-indexed loop keeps
  // the mux free of variable part-selects.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < K; k++) begin
      if (cnt_q == CW'(k)) begin
        a_slice = a_q[k*W +: W];
        b_slice = b_q[k*W +: W];
      end
    end
  end

  // W+1-bit sum so the slice carry is the top bit, never lost to truncation.
  assign slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};
  assign s_slice   = slice_res[W-1:0];
  assign c_slice   = slice_res[W];

`ifdef OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic msb_cin;
  // Carry into bit N-1 recovered from the sum bit: s = a ^ b ^ cin.
  assign msb_cin = a_slice[W-1] ^ b_slice[W-1] ^ s_slice[W-1];
`endif

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
`ifdef OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE lasts exactly one cycle; IDLE simply stays put.
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          // Subtract as a + ~b + 1: invert B here, inject the +1 as carry.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          sum_d   = '0;
          cnt_d   = '0;
`ifdef OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int k = 0; k < K; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*W +: W] = s_slice;
          end
        end
        carry_d = c_slice;
        if (cnt_q == LAST) begin
          co_d    = c_slice;
`ifdef OVF_FLAG_EN
          ovf_d   = msb_cin ^ c_slice;
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

`ifdef OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Status decoded straight from the state register, so both are glitch-free
  // and clear immediately on reset.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_serial_adder
//
// Self-checking bench for chunked_serial_adder (N=16, W=4). A behavioural
// model computes each result with plain integer arithmetic at accept time and
// tracks the K-cycle latency; a compare process checks busy/done/sum/co/ovf
// against it every cycle. Directed cases pin the model with literal values,
// then a randomized phase drives start/operands freely.
// Build option: OVF_FLAG_EN enables the ovf port and its checks.
// -----------------------------------------------------------------------------
module tb_chunked_serial_adder;

  localparam int N = 16;
  localparam int W = 4;
  localparam int K = N / W;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         ci    = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         co;
  logic         dut_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef OVF_FLAG_EN
  logic ovf;
  assign dut_ovf = ovf;
`else
  assign dut_ovf = 1'b0;
`endif

  chunked_serial_adder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
  } res_t;

  function automatic res_t golden(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic s, input logic c);
    res_t   r;
    longint ux, uy, ur, sx, sy, sr, smax, smin;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (N - 1)) - 1;
    smin = -(longint'(1) <<< (N - 1));
    if (s) begin
      ur   = ux - uy;
      sr   = sx - sy;
      r.co = (ux >= uy);
    end else begin
      ur   = ux + uy + longint'(c);
      sr   = sx + sy + longint'(c);
      r.co = (ur >= (longint'(1) <<< N));
    end
    r.sum = ur[N-1:0];
    r.ovf = (sr > smax) || (sr < smin);
    return r;
  endfunction

  int   m_rem;   // edges left until the result appears; 0 = ready for start
  logic m_done;
  res_t m_pend;
  res_t m_out;   // what the DUT outputs must show when not busy

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_out  <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_out  <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_rem     <= K;
        m_pend    <= golden(a, b, sub, ci);
        m_out.sum <= '0;
        m_out.ovf <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_busy", busy, (m_rem > 0));
      check("cmp_done", done, m_done);
`ifdef OVF_FLAG_EN
      check("cmp_ovf", dut_ovf, m_out.ovf);
`endif
      if (m_rem == 0) begin
        check("cmp_sum", sum, m_out.sum);
        check("cmp_co", co, m_out.co);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge; holds start for one edge and returns at the
  // negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                       input logic tsub, input logic tci);
    a     = ta;
    b     = tb_v;
    sub   = tsub;
    ci    = tci;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input int lat0, input string name,
                           input logic [N-1:0] es, input logic eco);
    int lat;
    int bc;
    lat = lat0;
    bc  = 0;
    while (done !== 1'b1 && lat < 4 * K + 10) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
    check({name, "_done_seen"}, done, 1'b1);
    check({name, "_latency"}, lat, K);
    check({name, "_busy_cycles"}, bc, K - lat0);
    check({name, "_sum"}, sum, es);
    check({name, "_co"}, co, eco);
    check({name, "_model_sum"}, m_out.sum, es);
  endtask

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input logic tsub, input logic tci, input string name,
                        input logic [N-1:0] es, input logic eco);
    issue(ta, tb_v, tsub, tci);
    wait_done(0, name, es, eco);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_co", co, 1'b0);
    check("rst_ovf", dut_ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, carry propagation, carry-in, subtract with/without borrow
    run_op(16'h000F, 16'h0001, 1'b0, 1'b0, "add_f_1", 16'h0010, 1'b0);
    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap", 16'h0000, 1'b1);
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, "add_ci", 16'h0000, 1'b1);
    @(negedge clk);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow", 16'hFFFE, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, "sub_noborrow", 16'h0002, 1'b1);
    @(negedge clk);

    // Signed overflow cases
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_add", 16'h8000, 1'b0);
`ifdef OVF_FLAG_EN
    check("ovf_add_flag", dut_ovf, 1'b1);
`endif
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "ovf_sub", 16'h7FFF, 1'b1);
`ifdef OVF_FLAG_EN
    check("ovf_sub_flag", dut_ovf, 1'b1);
`endif
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "no_ovf", 16'h2345, 1'b0);
`ifdef OVF_FLAG_EN
    check("no_ovf_flag", dut_ovf, 1'b0);
`endif
    repeat (2) @(negedge clk);

    // start during RUN is ignored; back-to-back accept from DONE
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, "ignore_start", 16'h3333, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "back2back", 16'h0002, 1'b0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of RUN
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_sum", sum, '0);
    check("midrst_co", co, 1'b0);
    check("midrst_ovf", dut_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, "post_rst", 16'hFFFF, 1'b0);

    // Randomized phase: the compare process does the checking
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = N'($urandom);
      b     = N'($urandom);
      sub   = 1'($urandom_range(0, 1));
      ci    = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    repeat (2 * K + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
